// File: rtl/cordic_sweep_seq.sv
// Angle-sweep sequencer for the CORDIC rotation core: folds each angle into
// the core's +/-90 degree range, times one rotation, and streams {angle,cos,sin}.
module cordic_sweep_seq #(
  parameter int          WAIT_CYCLES = 60,
  parameter logic [15:0] X0_INIT     = 16'h009B,
  parameter int          CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [16:0]      angle0_i,
  input  logic [16:0]      step_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      cordic_x0_o,
  output logic [15:0]      cordic_y0_o,
  output logic [15:0]      cordic_z0_o,
  output logic             cordic_start_o,
  input  logic [15:0]      cordic_xn_i,
  input  logic [15:0]      cordic_yn_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [16:0]      res_angle_o,
  output logic [15:0]      res_cos_o,
  output logic [15:0]      res_sin_o
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [16:0] FULL17 = 17'd92160;
  localparam logic [17:0] FULL18 = 18'd92160;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_OUT
  } state_t;

  state_t           state;
  logic [16:0]      angle;
  logic [16:0]      step;
  logic [CNT_W-1:0] count;
  logic [WW-1:0]    wcnt;
  logic             neg;

  logic [16:0] a0_fold;
  logic [17:0] sum;
  logic [16:0] next_a;
  logic [16:0] issue_a;
  logic [15:0] fz;
  logic        fneg;

  assign cordic_x0_o = X0_INIT;
  assign cordic_y0_o = 16'd0;

  assign a0_fold = (angle0_i >= FULL17) ? angle0_i - FULL17 : angle0_i;
  assign sum     = {1'b0, angle} + {1'b0, step};
  assign next_a  = (sum >= FULL18) ? 17'(sum - FULL18) : sum[16:0];
  assign issue_a = (state == S_IDLE) ? a0_fold : next_a;

  // Mod-2^16 subtraction is exact: every folded result fits in Q7.8.
  always_comb begin
    fz   = issue_a[15:0];
    fneg = 1'b0;
    if (issue_a <= 17'd23040) begin
      fz = issue_a[15:0];
    end else if (issue_a < 17'd69120) begin
      fz   = issue_a[15:0] - 16'd46080;
      fneg = 1'b1;
    end else begin
      fz = issue_a[15:0] - 16'd26624;
    end
  end

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return 16'd0 - v;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      angle          <= '0;
      step           <= '0;
      count          <= '0;
      wcnt           <= '0;
      neg            <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      cordic_z0_o    <= '0;
      cordic_start_o <= 1'b0;
      res_valid_o    <= 1'b0;
      res_angle_o    <= '0;
      res_cos_o      <= '0;
      res_sin_o      <= '0;
    end else begin
      cordic_start_o <= 1'b0;
      done_o         <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              angle          <= a0_fold;
              step           <= step_i;
              count          <= count_i;
              busy_o         <= 1'b1;
              cordic_start_o <= 1'b1;
              cordic_z0_o    <= fz;
              neg            <= fneg;
              state          <= S_ISSUE;
            end else begin
              done_o <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          wcnt  <= WW'(WAIT_CYCLES - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) state <= S_CAPTURE;
          else wcnt <= wcnt - 1'b1;
        end
        S_CAPTURE: begin
          res_cos_o   <= neg ? neg_sat(cordic_xn_i) : cordic_xn_i;
          res_sin_o   <= neg ? neg_sat(cordic_yn_i) : cordic_yn_i;
          res_angle_o <= angle;
          res_valid_o <= 1'b1;
          state       <= S_OUT;
        end
        S_OUT: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            count       <= count - 1'b1;
            angle       <= next_a;
            if (count == CNT_W'(1)) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= S_IDLE;
            end else begin
              cordic_start_o <= 1'b1;
              cordic_z0_o    <= fz;
              neg            <= fneg;
              state          <= S_ISSUE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_sweep_seq.md
Name: cordic_sweep_seq

Overview:
Upstream sequencer for the CORDIC rotation core. It generates a sweep of angles in degrees over [0,360), folds each angle into the core's ±90° convergence range and drives one rotation per angle. It waits a fixed core latency, captures xn/yn, sign-corrects them and presents {angle, cos, sin} on a ready/valid result stream. It replaces the bench's hand-timed start/wait loop in system use.

Parameters:
WAIT_CYCLES, 60, cycles from cordic_start_o to the sample of cordic_xn_i/cordic_yn_i; must be ≥1.
X0_INIT, 16'h009B, value driven on cordic_x0_o (CORDIC gain compensation 0.60546875, Q7.8).
CNT_W, 8, width of the sweep count.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  asynchronous, active-high reset.
start_i  in  1  one-cycle request to start a sweep; ignored while busy_o=1.
angle0_i  in  17  first angle, unsigned Q9.8 degrees.
step_i  in  17  angle increment, unsigned Q9.8; legal range < 92160 (360.0).
count_i  in  CNT_W  number of results in the sweep.
busy_o  out  1  high from the accepted start until the sweep ends.
done_o  out  1  one-cycle pulse at sweep end.
cordic_x0_o  out  16  constant X0_INIT.
cordic_y0_o  out  16  constant 0.
cordic_z0_o  out  16  folded angle, signed Q7.8; held until the next issue.
cordic_start_o  out  1  one-cycle rotation request.
cordic_xn_i  in  16  core cos output, signed Q7.8.
cordic_yn_i  in  16  core sin output, signed Q7.8.
res_valid_o  out  1  result valid.
res_ready_i  in  1  result accepted when valid&ready.
res_angle_o  out  17  unfolded angle for this result, Q9.8.
res_cos_o  out  16  signed Q7.8.
res_sin_o  out  16  signed Q7.8.

Behaviour:
- Reset (async): state=IDLE. All outputs 0 except cordic_x0_o=X0_INIT. Internal angle, step and count registers cleared. Reset mid-sweep abandons the sweep and emits no done_o.
- IDLE: busy_o=0.
  - start_i with count_i≠0: latch angle0 (if ≥92160, subtract 92160 once), step and count, then go to ISSUE.
  - start_i with count_i=0: done_o pulses on the next cycle and the block stays in IDLE.
- ISSUE (1 cycle): cordic_start_o=1. cordic_z0_o is registered with the folded angle a:
  - a ≤ 23040 (90.0): z=a, neg=0.
  - 23040 < a < 69120 (270.0): z=a−46080, neg=1.
  - a ≥ 69120: z=a−92160, neg=0.
  - Exact 90° gives z=+90; exact 270° gives z=−90.
  - Next state is WAIT, with the wait counter loaded to WAIT_CYCLES−1.
- WAIT: the counter decrements each cycle. At 0, go to CAPTURE.
- CAPTURE (1 cycle): sample cordic_xn_i/cordic_yn_i.
  - If neg=1, both results are negated, and −32768 saturates to 32767.
  - Load res_* and set res_valid_o=1, then go to OUT.
- OUT: res_* are held stable while res_valid_o=1 and res_ready_i=0. No cordic_start_o is issued during this stall.
  - On the handshake: res_valid_o drops, count decrements, and angle ← angle+step (subtract 92160 if the sum is ≥92160).
  - If the remaining count is 0, go to IDLE and pulse done_o in the same cycle busy_o falls.
  - Otherwise go to ISSUE.
- Latency: with start_i sampled at edge 0, cordic_start_o is high during cycle 1 and res_valid_o rises after edge WAIT_CYCLES+2.
  - With res_ready_i held high, results are spaced WAIT_CYCLES+3 cycles apart.
- Simultaneous events:
  - start_i during busy: ignored, no effect.
  - res_ready_i without res_valid_o: no effect.

Test Plan:
- Single sweep, angle0=20.0 (5120), count=1, ready=1 -> exactly one cordic_start_o, with cordic_z0_o=5120. Result cos≈240 and sin≈88 (±2 LSB). res_valid_o rises at edge 62. done_o pulses once.
- Folding, angle0=150.0, 90.0 and 270.0 (separate sweeps) -> z0 = −30.0 (−7680, neg), +90.0 and −90.0 respectively.
  - 150° result: cos≈−222, sin≈128.
  - 90°/270° results are not negated.
- Sweep angle0=10.0, step=5.0, count=15 -> res_angle_o runs 10,15,…,80 degrees. Each cos/sin is within ±2 LSB of the real values. Exactly 15 handshakes, then done_o.
- Wrap, angle0=350.0, step=20.0, count=3 -> res_angle_o = 350.0, 10.0, 30.0. The z0 values are −10.0, 10.0 and 30.0.
- Backpressure: ready held low for 10 cycles after valid -> res_* stable, no new cordic_start_o. The next issue occurs the cycle after the handshake.
- rst_i asserted mid-WAIT -> all outputs return to reset values asynchronously, with no done_o. count_i=0 -> done_o only, no cordic_start_o.
